// File: rtl/display_line_pingpong.sv
// Two-bank RGB888 line buffer: the producer fills one bank while the LCD timing controller reads the other.
// Optional LINE_BUF_UNDERRUN_CNT_EN adds the underrun_cnt port and its saturating counter.
module display_line_pingpong #(
  parameter int HDATA_T = 800
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic        display_en,
  input  logic        wr_valid,
  input  logic [23:0] wr_data,
  output logic        wr_ready,
  input  logic        rd_en,
  input  logic [15:0] px,
  output logic [23:0] rgb_data,
  output logic        underrun
`ifdef LINE_BUF_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int          DEPTH    = 2 * HDATA_T;
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [15:0] LAST_PX  = 16'(HDATA_T - 1);
  localparam logic [AW-1:0] BANK_OFS = AW'(HDATA_T);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

  state_t        r_state, w_state_next;
  logic [15:0]   r_wr_px, w_wr_px_next;
  logic          r_wr_bank, w_wr_bank_next;
  logic          r_rd_valid, w_rd_valid_next;
  logic          r_wr_ready;
  logic          r_rd_en_d;
  logic [23:0]   r_rgb;
  logic          r_underrun;
  logic          w_accept;
  logic          w_line_done;
  logic          w_swap_evt;
  logic          w_underrun_evt;
  logic          w_px_in_range;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_addr;

  logic [23:0]   r_mem [0:DEPTH-1];

  // wr_ready is high exactly while the FSM sits in FILL, so it alone qualifies a beat
  assign w_accept      = display_en && wr_valid && r_wr_ready;
  assign w_line_done   = (r_state == S_FULL) || (w_accept && (r_wr_px == LAST_PX));
  assign w_swap_evt    = r_rd_en_d && !rd_en;
  assign w_px_in_range = int'(px) < HDATA_T;
  assign w_wr_addr     = AW'(r_wr_px) + (r_wr_bank ? BANK_OFS : '0);
  assign w_rd_addr     = AW'(px) + (r_wr_bank ? '0 : BANK_OFS);

  always_comb begin
    w_state_next    = r_state;
    w_wr_px_next    = r_wr_px;
    w_wr_bank_next  = r_wr_bank;
    w_rd_valid_next = r_rd_valid;
    w_underrun_evt  = 1'b0;
    if (!display_en) begin
      w_state_next    = S_IDLE;
      w_wr_px_next    = '0;
      w_wr_bank_next  = 1'b0;
      w_rd_valid_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_FILL;
        S_FILL: begin
          if (w_accept) begin
            if (r_wr_px == LAST_PX) begin
              w_state_next = S_FULL;
              w_wr_px_next = '0;
            end else begin
              w_wr_px_next = r_wr_px + 16'd1;
            end
          end
        end
        default: w_state_next = r_state;
      endcase
      // A swap that finds the write bank incomplete leaves the read bank repeating its line
      if (w_swap_evt) begin
        if (w_line_done) begin
          w_wr_bank_next  = ~r_wr_bank;
          w_rd_valid_next = 1'b1;
          w_state_next    = S_FILL;
          w_wr_px_next    = '0;
        end else begin
          w_underrun_evt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_px    <= '0;
      r_wr_bank  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_wr_ready <= 1'b0;
      r_rd_en_d  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_px    <= w_wr_px_next;
      r_wr_bank  <= w_wr_bank_next;
      r_rd_valid <= w_rd_valid_next;
      r_wr_ready <= (w_state_next == S_FILL);
      r_rd_en_d  <= rd_en;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (w_accept) begin
      r_mem[w_wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else if (display_en && rd_en) begin
      r_rgb <= (r_rd_valid && w_px_in_range) ? r_mem[w_rd_addr] : '0;
    end
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_underrun_evt) begin
      r_underrun <= 1'b1;
    end
  end

`ifdef LINE_BUF_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      r_underrun_cnt <= '0;
    end else if (w_underrun_evt && (r_underrun_cnt != 16'hFFFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign wr_ready = r_wr_ready;
  assign rgb_data = r_rgb;
  assign underrun = r_underrun;

endmodule

// File: tb/tb_display_line_pingpong.sv
// Directed bench for display_line_pingpong with an 8-pixel line; each scenario task checks its own results.
// Define LINE_BUF_UNDERRUN_CNT_EN for both files to also check underrun_cnt.
module tb_display_line_pingpong;

  localparam int HD = 8;

  logic        pixel_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        display_en = 1'b0;
  logic        wr_valid = 1'b0;
  logic [23:0] wr_data = '0;
  logic        rd_en = 1'b0;
  logic [15:0] px = '0;
  logic        wr_ready;
  logic [23:0] rgb_data;
  logic        underrun;
`ifdef LINE_BUF_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  display_line_pingpong #(.HDATA_T(HD)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .display_en(display_en),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .rd_en     (rd_en),
    .px        (px),
    .rgb_data  (rgb_data),
    .underrun  (underrun)
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    ,
    .underrun_cnt(underrun_cnt)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; display_en = 1'b1; wr_valid = 1'b0; rd_en = 1'b0; px = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic write_beats(input logic [23:0] base, input int n);
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + 24'(i);
      tick();
    end
    wr_valid = 1'b0;
    $display("write %0d beats starting at %h", n, base);
  endtask

  task automatic read_line_nocheck();
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
    end
  endtask

  task automatic end_line();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; display_en = 1'b1; wr_valid = 1'b0; rd_en = 1'b0;
    repeat (3) tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL reset_wr_ready: got %b expected 0", wr_ready); end
    n_cmp++; if (rgb_data !== 24'h0) begin n_err++; $display("FAIL reset_rgb: got %h expected 000000", rgb_data); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h expected 0000", underrun_cnt); end
`endif
    rst_n = 1'b1;
    tick(); tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b expected 1", wr_ready); end
    $display("test_reset done");
  endtask

  task automatic test_fill_swap();
    do_reset();
    write_beats(24'h000001, HD);
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b expected 0", wr_ready); end
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h0) begin n_err++; $display("FAIL fill_first_line px=%0d: got %h expected 000000", p, rgb_data); end
    end
    end_line();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL swap_ready: got %b expected 1", wr_ready); end
    write_beats(24'h000011, HD);
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'(p + 1)) begin n_err++; $display("FAIL fill_second_line px=%0d: got %h expected %h", p, rgb_data, 24'(p + 1)); end
    end
    end_line();
    rd_en = 1'b1; px = 16'(HD);
    tick();
    n_cmp++; if (rgb_data !== 24'h0) begin n_err++; $display("FAIL px_out_of_range: got %h expected 000000", rgb_data); end
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h11 + 24'(p)) begin n_err++; $display("FAIL fill_third_line px=%0d: got %h expected %h", p, rgb_data, 24'h11 + 24'(p)); end
    end
    rd_en = 1'b0; px = 16'd2;
    tick();
    n_cmp++; if (rgb_data !== 24'h000018) begin n_err++; $display("FAIL rd_hold: got %h expected 000018", rgb_data); end
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL empty_bank_underrun: got %b expected 1", underrun); end
    $display("test_fill_swap done");
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      wr_valid = (c % 2 == 0);
      wr_data = 24'h20 + 24'(c / 2);
      tick();
      n_cmp++; if (wr_ready !== (c < 14)) begin n_err++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, wr_ready, (c < 14)); end
    end
    wr_valid = 1'b0;
    read_line_nocheck();
    end_line();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL bp_swap_ready: got %b expected 1", wr_ready); end
    write_beats(24'h000030, HD);
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h20 + 24'(p)) begin n_err++; $display("FAIL bp_line px=%0d: got %h expected %h", p, rgb_data, 24'h20 + 24'(p)); end
    end
    end_line();
    $display("test_backpressure done");
  endtask

  task automatic test_underrun();
    do_reset();
    write_beats(24'h000001, HD);
    read_line_nocheck();
    end_line();
    write_beats(24'h000041, 5);
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'(p + 1)) begin n_err++; $display("FAIL ur_line px=%0d: got %h expected %h", p, rgb_data, 24'(p + 1)); end
    end
    end_line();
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL ur_flag: got %b expected 1", underrun); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL ur_ready: got %b expected 1", wr_ready); end
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'd1) begin n_err++; $display("FAIL ur_cnt: got %0d expected 1", underrun_cnt); end
`endif
    write_beats(24'h000046, 3);
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'(p + 1)) begin n_err++; $display("FAIL ur_repeat px=%0d: got %h expected %h", p, rgb_data, 24'(p + 1)); end
    end
    end_line();
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h41 + 24'(p)) begin n_err++; $display("FAIL ur_completed px=%0d: got %h expected %h", p, rgb_data, 24'h41 + 24'(p)); end
    end
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'd1) begin n_err++; $display("FAIL ur_cnt_after: got %0d expected 1", underrun_cnt); end
`endif
    $display("test_underrun done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    write_beats(24'h000001, HD);
    read_line_nocheck();
    end_line();
    write_beats(24'h000051, HD - 1);
    read_line_nocheck();
    rd_en = 1'b0; wr_valid = 1'b1; wr_data = 24'h000058;
    tick();
    wr_valid = 1'b0;
    n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL sim_underrun: got %b expected 0", underrun); end
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL sim_ready: got %b expected 1", wr_ready); end
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h51 + 24'(p)) begin n_err++; $display("FAIL sim_line px=%0d: got %h expected %h", p, rgb_data, 24'h51 + 24'(p)); end
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_flush();
    do_reset();
    write_beats(24'h000001, HD);
    read_line_nocheck();
    end_line();
    read_line_nocheck();
    end_line();
    write_beats(24'h000061, 4);
    display_en = 1'b0;
    tick();
    n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b expected 0", wr_ready); end
    tick();
    n_cmp++; if (rgb_data !== 24'h000008) begin n_err++; $display("FAIL flush_rgb_hold: got %h expected 000008", rgb_data); end
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL flush_underrun: got %b expected 1", underrun); end
    display_en = 1'b1;
    tick();
    n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reenable_ready: got %b expected 1", wr_ready); end
    write_beats(24'h000071, HD);
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h0) begin n_err++; $display("FAIL flush_zero px=%0d: got %h expected 000000", p, rgb_data); end
    end
    end_line();
    for (int p = 0; p < HD; p++) begin
      rd_en = 1'b1; px = 16'(p);
      tick();
      n_cmp++; if (rgb_data !== 24'h71 + 24'(p)) begin n_err++; $display("FAIL flush_line px=%0d: got %h expected %h", p, rgb_data, 24'h71 + 24'(p)); end
    end
    n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL flush_underrun_kept: got %b expected 1", underrun); end
`ifdef LINE_BUF_UNDERRUN_CNT_EN
    n_cmp++; if (underrun_cnt !== 16'd1) begin n_err++; $display("FAIL flush_cnt: got %0d expected 1", underrun_cnt); end
`endif
    $display("test_flush done");
  endtask

  initial begin
    test_reset();
    test_fill_swap();
    test_backpressure();
    test_underrun();
    test_simultaneous();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/display_line_pingpong.md
# display_line_pingpong

Two-bank (ping-pong) line buffer between the pixel source and the LCD timing controller. An upstream producer streams one line of RGB888 pixels into the write bank over a valid/ready handshake. The timing controller reads the other bank with its `rd_en`/`px` strobes and receives `rgb_data` one cycle later. Banks swap at the end of each active read line, so a full line is always presented while the next one is being filled.

## Interface
Parameters:
- `HDATA_T`, 800, pixels per active line (bank depth); legal range 4..32768.

Ports:
- `pixel_clk`  in  1  sole clock; all logic on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `display_en`  in  1  low synchronously flushes buffer state (see Operation).
- `wr_valid`  in  1  upstream pixel valid.
- `wr_data`  in  24  upstream pixel, {R,G,B}.
- `wr_ready`  out  1  buffer accepts `wr_data` this cycle.
- `rd_en`  in  1  read strobe from the timing controller; high during active pixels.
- `px`  in  16  pixel index for the current read.
- `rgb_data`  out  24  registered read data.
- `underrun`  out  1  sticky; set on any swap attempt with the write bank not full.
- `underrun_cnt`  out  16  present only with `LINE_BUF_UNDERRUN_CNT_EN`.

## Operation
- Storage: `mem[2][HDATA_T]` × 24 bits. State: `wr_bank` and `rd_bank` (always opposite), `rd_valid` flag, write counter `wr_px` (16 bits).
- Write FSM states:
  - IDLE: `wr_ready`=0. Moves to FILL on the first cycle with `display_en`=1.
  - FILL: `wr_ready`=1. A beat is accepted when `wr_valid && wr_ready`; it writes `mem[wr_bank][wr_px]` and increments `wr_px`. Accepting beat `HDATA_T-1` moves to FULL, with `wr_px` reset to 0.
  - FULL: `wr_ready`=0. Waits for the swap event.
- Swap event: `rd_en` delayed by one register is 1 and `rd_en` is 0, i.e. the falling edge marking the end of an active read line.
  - Write bank FULL (including the last beat accepted in the same cycle as the event): toggle both bank pointers, set `rd_valid`=1, FSM goes to FILL on the new write bank.
  - Write bank not full: no toggle. The read bank repeats its line, `underrun` is set, the counter increments, and the FSM stays in FILL with `wr_px` preserved.
- Read:
  - When `rd_en`=1, `rgb_data` ← `mem[rd_bank][px]`.
  - It returns 0 instead if `rd_valid`=0 or `px` ≥ `HDATA_T`.
  - When `rd_en`=0, `rgb_data` holds its value.
- `display_en`=0, synchronous and taking priority over everything except reset:
  - FSM goes to IDLE; `wr_px`=0, `wr_bank`=0, `rd_bank`=1, `rd_valid`=0.
  - `rgb_data` holds; `underrun` and the counter are kept.
  - Memory contents are not cleared.
- Reset, synchronous; can occur at any point, including mid-line:
  - FSM goes to IDLE; `wr_px`=0, `wr_bank`=0, `rd_bank`=1, `rd_valid`=0.
  - Outputs: `wr_ready`=0, `rgb_data`=0, `underrun`=0, `underrun_cnt`=0.

## Timing
- Read latency: exactly 1 cycle from the `rd_en`/`px` sample to `rgb_data`. This matches a controller that asserts `de` one cycle after `rd_en`.
- `wr_ready` is a registered FSM decode:
  - It rises the cycle after FSM entry to FILL.
  - It falls the cycle after the final beat is accepted.
  - There is no combinational path from `wr_valid` to `wr_ready`.
- A swap takes effect on the cycle after the falling edge of `rd_en`. A `rd_en` rising edge one cycle later already reads the new bank.
- Write and read never address the same bank in the same cycle. Both can be active in every cycle.
- `underrun_cnt` saturates at 16'hFFFF.

## Configuration
- `LINE_BUF_UNDERRUN_CNT_EN` defined: the `underrun_cnt` port and its 16-bit saturating counter are compiled in. The counter increments once per underrun swap event and is cleared only by reset.
- Not defined: the port and counter are absent. The sticky `underrun` flag alone reports underruns.

## Test plan
All scenarios use `HDATA_T`=8.
- Reset behaviour: assert `rst_n`=0 for 3 cycles while `display_en`=1 → `wr_ready`=0, `rgb_data`=0, `underrun`=0. Release reset → `wr_ready`=1 by the second cycle after release.
- Fill and swap:
  - Stimulus: write 24'h000001..24'h000008 with `wr_valid` held high, then pulse `rd_en` for 8 cycles with `px`=0..7.
  - During that first line: `rgb_data` reads 0 throughout, since `rd_valid`=0.
  - After the falling edge: the swap occurs and `wr_ready` returns to 1.
  - A second 8-cycle `rd_en` burst returns 1..8 with 1-cycle latency.
- Backpressure: `wr_valid` toggled every other cycle → exactly 8 beats are accepted. `wr_ready`=0 after the 8th beat until the next swap. Extra `wr_valid` beats are not written.
- Underrun: only 5 of 8 beats written before the `rd_en` falling edge → `underrun`=1 (and `underrun_cnt`=1 if enabled). The next read line repeats the previous line's data. Writing the remaining 3 beats, followed by a swap, presents the completed line.
- Simultaneous event: the 8th write beat is accepted in the same cycle as the `rd_en` falling edge → the swap happens, `underrun` stays 0, and the new line is read next.
- Flush: drop `display_en` mid-fill (after 4 beats) for 2 cycles → `wr_ready`=0 and the next reads return 0. After re-enable, 8 new beats plus a swap yield correct data, and the `underrun` value is unchanged.
